// File: rtl/sequence_arbiter_pkg.sv
// Shared types and sizing for the sequence arbiter and the ps2_*_ascii sequence sources.
// Purely declarative: no logic, no latency, no backpressure.
package seq_pkg;

  localparam int BYTE_WIDTH      = 8;
  localparam int DEF_COUNT_WIDTH = 3;
  localparam int DEF_MAX_BYTES   = 4;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    GAP
  } state_t;

  function automatic int slice_width(input int count_width, input int max_bytes);
    return count_width + BYTE_WIDTH * max_bytes;
  endfunction

  function automatic int index_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/sequence_arbiter_if.sv
// Sequence-channel inputs and serial byte output of the sequence arbiter.
// slave = arbiter side, master = sources/downstream side.
interface sequence_arbiter_if
  import seq_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int MAX_BYTES   = DEF_MAX_BYTES,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
);
  localparam int SLICE_W = slice_width(COUNT_WIDTH, MAX_BYTES);

  logic [CHANNELS*SLICE_W-1:0] in_data;
  logic [CHANNELS-1:0]         in_data_available;
  logic [CHANNELS-1:0]         in_data_ready;
  logic                        receiver_ready;
  logic                        out_data_available;
  logic [BYTE_WIDTH-1:0]       out_data;
  logic                        busy;

  modport master (
    output in_data, in_data_available, receiver_ready,
    input  in_data_ready, out_data_available, out_data, busy
  );

  modport slave (
    input  in_data, in_data_available, receiver_ready,
    output in_data_ready, out_data_available, out_data, busy
  );

endinterface

// File: rtl/sequence_arbiter_rr_arbiter.sv
// Combinational channel picker: round-robin from last_grant+1, or lowest index when
// FIXED_PRIORITY_EN is defined. Zero latency; grant is all-zero when disabled or idle.
module rr_arbiter
  import seq_pkg::*;
#(
  parameter int CHANNELS = 2,
  localparam int IDX_W   = index_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] request,
  input  logic [IDX_W-1:0]    last_grant,
  input  logic                enable,
  output logic [CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]    grant_index
);

`ifdef FIXED_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  always_comb begin
    int   c;
    logic found;
    grant       = '0;
    grant_index = '0;
    found       = 1'b0;
    c           = 0;
    for (int off = 0; off < CHANNELS; off++) begin
`ifdef FIXED_PRIORITY_EN
      c = off;
`else
      c = (int'(last_grant) + 1 + off) % CHANNELS;
`endif
      if (enable && !found && request[IDX_W'(c)]) begin
        found              = 1'b1;
        grant[IDX_W'(c)]   = 1'b1;
        grant_index        = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/sequence_arbiter.sv
// Arbitrates N {count, bytes} sequence channels and serialises the winner byte 0 first,
// one strobe per two cycles; receiver_ready=0 stalls in EMIT. Macro FIXED_PRIORITY_EN selects fixed priority.
module sequence_arbiter
  import seq_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int MAX_BYTES   = DEF_MAX_BYTES,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input logic          clk,
  input logic          reset_n,
  sequence_arbiter_if.slave bus
);

  localparam int SLICE_W = slice_width(COUNT_WIDTH, MAX_BYTES);
  localparam int DATA_W  = BYTE_WIDTH * MAX_BYTES;
  localparam int IDX_W   = index_width(CHANNELS);
  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_BYTES);
  localparam logic [IDX_W-1:0]       LAST_CH   = IDX_W'(CHANNELS - 1);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       grant_index;
  logic [CHANNELS-1:0]    grant;
  logic [CHANNELS-1:0]    ready_q, ready_nxt;
  logic [COUNT_WIDTH-1:0] count_q, idx_q, idx_nxt, sel_count;
  logic [DATA_W-1:0]      bytes_q;
  logic [SLICE_W-1:0]     sel_slice;
  logic [BYTE_WIDTH-1:0]  cur_byte, out_q, out_nxt;
  logic                   strobe_q, strobe_nxt;
  logic                   take;

  // A channel whose pop strobe is in flight still shows available; mask it so it is not popped twice.
  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .request     (bus.in_data_available & ~ready_q),
    .last_grant  (last_grant),
    .enable      (state == IDLE),
    .grant       (grant),
    .grant_index (grant_index)
  );

  assign take = |grant;

  always_comb begin
    sel_slice = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_index == IDX_W'(i)) sel_slice = bus.in_data[i*SLICE_W +: SLICE_W];
    end
    sel_count = sel_slice[SLICE_W-1 -: COUNT_WIDTH];
    if (sel_count > MAX_COUNT) sel_count = MAX_COUNT;
  end

  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (idx_q == COUNT_WIDTH'(k)) cur_byte = bytes_q[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx_q;
    ready_nxt  = '0;
    strobe_nxt = 1'b0;
    out_nxt    = out_q;
    unique case (state)
      IDLE: begin
        if (take) begin
          ready_nxt = grant;
          if (sel_count != '0) state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (bus.receiver_ready) begin
          strobe_nxt = 1'b1;
          out_nxt    = cur_byte;
          idx_nxt    = idx_q + COUNT_WIDTH'(1);
          state_nxt  = GAP;
        end
      end
      GAP: begin
        if (idx_q == count_q) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          state_nxt = EMIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx_q    <= '0;
      ready_q  <= '0;
      strobe_q <= 1'b0;
      out_q    <= '0;
    end else begin
      state    <= state_nxt;
      idx_q    <= idx_nxt;
      ready_q  <= ready_nxt;
      strobe_q <= strobe_nxt;
      out_q    <= out_nxt;
    end
  end

  // last_grant resets to the top channel so the first round-robin search starts at channel 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= LAST_CH;
      count_q    <= '0;
      bytes_q    <= '0;
    end else if (take) begin
      last_grant <= grant_index;
      count_q    <= sel_count;
      bytes_q    <= sel_slice[DATA_W-1:0];
    end
  end

  assign bus.in_data_ready      = ready_q;
  assign bus.out_data_available = strobe_q;
  assign bus.out_data           = out_q;
  assign bus.busy               = (state != IDLE);

endmodule

// File: tb/tb_sequence_arbiter.sv
// Directed bench for sequence_arbiter: FIFO model per channel, byte/grant logs, hand-computed expectations.
module tb_sequence_arbiter;
  import seq_pkg::*;

  localparam int CH = 2;
  localparam int MB = 4;
  localparam int CW = 3;
  localparam int SW = slice_width(CW, MB);

  typedef struct {
    int          ch;
    logic [2:0]  cnt;
    logic [31:0] bytes;
    int          exp_n;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sequence_arbiter_if #(.CHANNELS(CH), .MAX_BYTES(MB), .COUNT_WIDTH(CW)) bus ();

  sequence_arbiter #(.CHANNELS(CH), .MAX_BYTES(MB), .COUNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [SW-1:0] fq0[$];
  logic [SW-1:0] fq1[$];
  logic [7:0]    got[$];
  int            got_cyc[$];
  int            gnt[$];
  int            gnt_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [SW-1:0] mk(input logic [2:0] cnt, input logic [31:0] b);
    return {cnt, b};
  endfunction

  task automatic refresh();
    bus.in_data_available[0] = (fq0.size() != 0);
    bus.in_data_available[1] = (fq1.size() != 0);
    bus.in_data[SW-1:0]      = (fq0.size() != 0) ? fq0[0] : '0;
    bus.in_data[2*SW-1:SW]   = (fq1.size() != 0) ? fq1[0] : '0;
  endtask

  task automatic push(input int ch, input logic [SW-1:0] s);
    if (ch == 0) fq0.push_back(s);
    else fq1.push_back(s);
    refresh();
  endtask

  task automatic clear_logs();
    got.delete();
    got_cyc.delete();
    gnt.delete();
    gnt_cyc.delete();
  endtask

  // One clock: FIFOs pop on the edge that ends a ready cycle, then outputs are logged.
  task automatic tick();
    logic [CH-1:0] pend;
    pend = bus.in_data_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (pend[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (pend[1] && fq1.size() != 0) void'(fq1.pop_front());
    refresh();
    if (bus.out_data_available) begin
      got.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end
    if (|bus.in_data_ready) begin
      chk("ready_onehot", $countones(bus.in_data_ready), 1);
      gnt.push_back(bus.in_data_ready[1] ? 1 : 0);
      gnt_cyc.push_back(cyc);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_got(input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_strobes", got.size(), n);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fq0.delete();
    fq1.delete();
    refresh();
    run(2);
    reset_n = 1'b1;
    run(1);
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    int          p;
    int          exp_g[4];
    logic [7:0]  exp_b[4];
    logic [31:0] b;

    tbl[0] = '{0, 3'd3, 32'h00415B1B, 3};
    tbl[1] = '{1, 3'd4, 32'h44332211, 4};
    tbl[2] = '{0, 3'd7, 32'hDDCCBBAA, 4};
    tbl[3] = '{1, 3'd1, 32'h0000005A, 1};
    tbl[4] = '{1, 3'd0, 32'h77777777, 0};
    tbl[5] = '{0, 3'd5, 32'h0D0C0B0A, 4};
    tbl[6] = '{0, 3'd2, 32'h0000F0E1, 2};

    bus.in_data           = '0;
    bus.in_data_available = '0;
    bus.receiver_ready    = 1'b1;
    reset_n               = 1'b0;
    run(2);
    chk("rst_ready", bus.in_data_ready, 0);
    chk("rst_strobe", bus.out_data_available, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    run(1);
    clear_logs();

    // Timing of a 3-byte sequence on channel 0.
    p = cyc;
    push(0, mk(3'd3, 32'h00415B1B));
    tick();
    chk("t1_ready", bus.in_data_ready, 2'b01);
    chk("t1_busy_emit", bus.busy, 1);
    run(5);
    chk("t1_last_strobe", bus.out_data_available, 1);
    chk("t1_busy_last_gap", bus.busy, 1);
    tick();
    chk("t1_busy_fall", bus.busy, 0);
    run(3);
    chk("t1_nbytes", got.size(), 3);
    if (got.size() == 3) begin
      chk("t1_b0", got[0], 8'h1B);
      chk("t1_b1", got[1], 8'h5B);
      chk("t1_b2", got[2], 8'h41);
      chk("t1_c0", got_cyc[0], p + 2);
      chk("t1_c1", got_cyc[1], p + 4);
      chk("t1_c2", got_cyc[2], p + 6);
    end

    // Single-sequence vectors, including count clamp and count 0.
    for (int i = 0; i < 7; i++) begin
      clear_logs();
      push(tbl[i].ch, mk(tbl[i].cnt, tbl[i].bytes));
      run(20);
      b = tbl[i].bytes;
      chk($sformatf("v%0d_npops", i), gnt.size(), 1);
      if (gnt.size() > 0) chk($sformatf("v%0d_grant", i), gnt[0], tbl[i].ch);
      chk($sformatf("v%0d_nbytes", i), got.size(), tbl[i].exp_n);
      for (int k = 0; k < tbl[i].exp_n; k++) begin
        if (k < got.size()) chk($sformatf("v%0d_byte%0d", i, k), got[k], b[8*k +: 8]);
      end
    end

    // Grant order with both channels holding two sequences.
    do_reset();
`ifdef FIXED_PRIORITY_EN
    exp_g = '{0, 0, 1, 1};
    exp_b = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
`else
    exp_g = '{0, 1, 0, 1};
    exp_b = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
`endif
    fq0.push_back(mk(3'd1, 32'h000000A0));
    fq0.push_back(mk(3'd1, 32'h000000A1));
    fq1.push_back(mk(3'd1, 32'h000000B0));
    fq1.push_back(mk(3'd1, 32'h000000B1));
    refresh();
    run(30);
    chk("order_npops", gnt.size(), 4);
    chk("order_nbytes", got.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gnt.size()) chk($sformatf("order_grant%0d", k), gnt[k], exp_g[k]);
      if (k < got.size()) chk($sformatf("order_byte%0d", k), got[k], exp_b[k]);
    end

    // receiver_ready stall while EMIT holds byte 1.
    clear_logs();
    push(0, mk(3'd3, 32'h00C3C2C1));
    wait_got(1, 10);
    bus.receiver_ready = 1'b0;
    run(11);
    chk("stall_nbytes", got.size(), 1);
    chk("stall_busy", bus.busy, 1);
    bus.receiver_ready = 1'b1;
    tick();
    chk("stall_release_strobe", bus.out_data_available, 1);
    chk("stall_release_data", bus.out_data, 8'hC2);
    run(10);
    chk("stall_total", got.size(), 3);
    if (got.size() == 3) begin
      chk("stall_b1", got[1], 8'hC2);
      chk("stall_b2", got[2], 8'hC3);
    end

    // Count 0 on ch1: one pop, no bytes, next channel popped the following cycle.
    do_reset();
    p = cyc;
    push(1, mk(3'd0, 32'h99999999));
    tick();
    push(0, mk(3'd1, 32'h00000066));
    run(10);
    chk("zero_npops", gnt.size(), 2);
    if (gnt.size() == 2) begin
      chk("zero_g0", gnt[0], 1);
      chk("zero_c0", gnt_cyc[0], p + 1);
      chk("zero_g1", gnt[1], 0);
      chk("zero_c1", gnt_cyc[1], p + 2);
    end
    chk("zero_nbytes", got.size(), 1);
    if (got.size() == 1) chk("zero_byte", got[0], 8'h66);

    // Reset after byte 2 of 4: nothing replayed, next sequence starts at byte 0.
    clear_logs();
    push(0, mk(3'd4, 32'hD3D2D1D0));
    wait_got(2, 10);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_strobe", bus.out_data_available, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.in_data_ready, 0);
    run(2);
    reset_n = 1'b1;
    clear_logs();
    push(0, mk(3'd2, 32'h0000E1E0));
    run(15);
    chk("post_rst_nbytes", got.size(), 2);
    if (got.size() == 2) begin
      chk("post_rst_b0", got[0], 8'hE0);
      chk("post_rst_b1", got[1], 8'hE1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_arbiter.md
Name: sequence_arbiter

Overview:
Generalised successor to the keyboard/mouse sequence muxer and byte serialiser pair. It takes N sequence channels, each carrying {count, up to MAX_BYTES bytes}, and arbitrates between them round-robin. The selected sequence is emitted byte by byte toward serial_out. It sits between the per-source sequence FIFOs and serial_out, so that new sources (e.g. status reports, joystick) attach without touching the top level.

Parameters:
CHANNELS, 2, number of input sequence channels (1..8).
MAX_BYTES, 4, maximum bytes per sequence.
COUNT_WIDTH, 3, width of the per-sequence byte count field; must hold MAX_BYTES.

Ports:
clk  input  1  system clock (108 MHz domain).
reset_n  input  1  asynchronous active-low reset.
in_data  input  CHANNELS*(COUNT_WIDTH+8*MAX_BYTES)  channel i occupies slice i; within a slice, count is the top COUNT_WIDTH bits and byte k is bits [8k+7:8k].
in_data_available  input  CHANNELS  channel i has a sequence pending.
in_data_ready  output  CHANNELS  one-cycle pop strobe to channel i's FIFO.
receiver_ready  input  1  downstream can accept a byte (~sending).
out_data_available  output  1  one-cycle byte strobe.
out_data  output  8  byte value, valid when out_data_available=1.
busy  output  1  high while a sequence is held or being emitted.

Behaviour:
- Reset (asynchronous, reset_n=0): in_data_ready=0, out_data_available=0, out_data=8'h00, busy=0, state=IDLE, round-robin pointer=0, byte index=0. Reset asserted mid-sequence discards the remaining bytes; nothing is replayed after release.
- States: IDLE, EMIT, GAP.
- IDLE:
  - Arbiter selects the first requesting channel starting at (last_grant+1) mod CHANNELS.
  - On grant of channel g: pulse in_data_ready[g] for exactly 1 cycle, latch slice g, set last_grant=g, go to EMIT.
  - Latched count is clamped to MAX_BYTES.
  - Count 0: the sequence is popped and discarded, state stays IDLE, no output.
  - Grant latency: 1 cycle from available to ready pulse.
- EMIT: when receiver_ready=1, drive out_data=byte[idx] with a 1-cycle out_data_available pulse, increment idx, go to GAP. When receiver_ready=0, hold state.
- GAP: exactly one cycle, covering serial_out's 1-cycle lag before sending rises. Then:
  - If idx==count: go to IDLE, idx=0.
  - Otherwise: go to EMIT.
- Byte order: byte 0 is emitted first.
- Minimum spacing between strobes is 2 cycles.
- busy=1 in EMIT and GAP.
- Only one in_data_ready bit is ever high. No channel is popped while busy.
- All requesting: grants rotate 0,1,..,N-1,0. A single requester is granted back to back with a 1-cycle IDLE between sequences.
- Pointer wraps from CHANNELS-1 to 0. Granting channel g with CHANNELS=1 is legal.
- in_data is sampled only in the grant cycle; later changes have no effect.

Optional Feature:
FIXED_PRIORITY_EN
- Defined: the arbiter ignores the round-robin pointer, and the lowest-index requesting channel always wins. Keyboard (channel 0) therefore pre-empts mouse between sequences, never mid-sequence.
- Undefined: round-robin as above.
- Latency and handshakes are identical in both modes.

Decomposition:
- Package seq_pkg holds:
  - BYTE_WIDTH=8.
  - The state enum {IDLE, EMIT, GAP}.
  - Function slice_width(COUNT_WIDTH, MAX_BYTES).
  - Default COUNT_WIDTH and MAX_BYTES, shared with the ps2_*_ascii blocks.
- Sub-module rr_arbiter (parameter CHANNELS): inputs request, last_grant, enable; outputs one-hot grant and grant_index. It is purely combinational, and FIXED_PRIORITY_EN lives there.
- The FSM and serialiser stay in sequence_arbiter.

Test Plan:
- Ch0 count=3 bytes {1B,5B,41}, receiver_ready=1:
  - in_data_ready=01 one cycle later.
  - Outputs 1B,5B,41 on strobes 2 cycles apart.
  - busy falls after the last GAP.
- Ch0 and ch1 each hold 2 sequences, all pending together: grant order 0,1,0,1. Under FIXED_PRIORITY_EN: 0,0,1,1.
- receiver_ready held low for 10 cycles during EMIT of byte 1: no strobe and state held. On release the strobe fires on the next cycle and byte 1 is not repeated.
- Count=0 on ch1: single ready pulse, zero output strobes, next pending channel granted one cycle later.
- Count=7 with MAX_BYTES=4: exactly 4 bytes emitted.
- reset_n low after byte 2 of 4: outputs cleared immediately. After release, the next sequence starts at its byte 0 and the old bytes 2-3 are never sent.
